// File: rtl/dig_in_event_fifo.sv
// Digital-input event FIFO on the DSP external bus.
// Watches 16 asynchronous input lines, timestamps every change with a
// prescaled free-running counter and queues {snapshot, timestamp} pairs in a
// 16-deep FIFO. The DSP drains the FIFO via bus reads. A SNAP read pops the
// head entry once the read strobe ends.
//
// Handshake: the bus front end qualifies strobes. A write acts only on the
// first cycle of write_qualified (rising edge) with a matching address. Reads
// are claimed combinationally while read_qualified is high. A SNAP read arms
// pop_pend, and the pop happens on the first edge that samples
// read_qualified low, so a multi-cycle read pops exactly once.
module dig_in_event_fifo #(
  parameter logic [7:0] ab_offset = 8'h00
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        write_qualified,
  input  logic        read_qualified,
  input  logic [7:0]  ab,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        data_avail,
  input  logic [15:0] dig_in,
  output logic        event_irq
);

  localparam logic [7:0] BASE         = 8'h60 + ab_offset;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_TSTAMP   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [4:0] DEPTH        = 5'd16;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        enable_q,     enable_d;
  logic        irq_en_q,     irq_en_d;
  logic [15:0] prescale_q,   prescale_d;
  logic [15:0] presc_cnt_q,  presc_cnt_d;
  logic [15:0] tstamp_q,     tstamp_d;
  logic [15:0] sync1_q,      sync1_d;
  logic [15:0] sync2_q,      sync2_d;
  logic [15:0] prev_q,       prev_d;
  logic [3:0]  wr_ptr_q,     wr_ptr_d;
  logic [3:0]  rd_ptr_q,     rd_ptr_d;
  logic [4:0]  count_q,      count_d;
  logic        overflow_q,   overflow_d;
  logic        pop_pend_q,   pop_pend_d;
  logic        wq_prev_q,    wq_prev_d;
  logic        event_irq_q,  event_irq_d;
  logic [31:0] mem_q [16];

  // ---------------------------------------------------------------------------
  // Address decode and strobes
  // ---------------------------------------------------------------------------
  logic [7:0]  reg_off;
  logic        addr_hit;
  logic [2:0]  reg_sel;
  logic        wr_fire;
  logic        ctrl_wr;
  logic        presc_wr;
  logic        clear_strobe;
  logic        fifo_empty;
  logic        fifo_full;
  logic        rd_snap;
  logic        do_pop;
  logic        event_det;
  logic        push_req;
  logic        push_ok;
  logic        tick;
  logic [31:0] head_entry;
  logic [31:0] push_entry;
  logic [15:0] rd_data;

  // Offset arithmetic wraps modulo 256, so any base decodes correctly.
  assign reg_off  = ab - BASE;
  assign addr_hit = (reg_off < 8'd5);
  assign reg_sel  = reg_off[2:0];

  assign wr_fire      = write_qualified & ~wq_prev_q & addr_hit;
  assign ctrl_wr      = wr_fire & (reg_sel == REG_CTRL);
  assign presc_wr     = wr_fire & (reg_sel == REG_PRESCALE);
  assign clear_strobe = ctrl_wr & db_in[1];

  assign fifo_empty = (count_q == 5'd0);
  assign fifo_full  = (count_q == DEPTH);
  assign head_entry = mem_q[rd_ptr_q];
  assign push_entry = {sync2_q, tstamp_q};

  assign rd_snap   = read_qualified & addr_hit & (reg_sel == REG_SNAP) & ~fifo_empty;
  // Pop on the first edge after the read strobe drops; clear wins over it.
  assign do_pop    = pop_pend_q & ~read_qualified & ~fifo_empty & ~clear_strobe;
  assign event_det = enable_q & (sync2_q != prev_q);
  assign push_req  = event_det & ~clear_strobe;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign push_ok   = push_req & (~fifo_full | do_pop);
  assign tick      = (presc_cnt_q >= prescale_q);

  // Control and prescale registers, written on the first qualified cycle only.
  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    wq_prev_d  = write_qualified;
    if (ctrl_wr) begin
      enable_d = db_in[0];
      irq_en_d = db_in[2];
    end
    if (presc_wr) begin
      prescale_d = db_in;
    end
  end

  // Timestamp: advances once every prescale+1 cycles, restarted by clear.
  always_comb begin
    presc_cnt_d = presc_cnt_q + 16'd1;
    tstamp_d    = tstamp_q;
    if (clear_strobe) begin
      presc_cnt_d = 16'd0;
      tstamp_d    = 16'd0;
    end else if (tick) begin
      presc_cnt_d = 16'd0;
      tstamp_d    = tstamp_q + 16'd1;
    end
  end

  // Two-stage synchronizer plus previous-value register for change detect.
  always_comb begin
    sync1_d = dig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // FIFO pointers, occupancy, sticky overflow and the pending-pop flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    pop_pend_d  = pop_pend_q;
    event_irq_d = irq_en_q & ~fifo_empty;
    if (clear_strobe) begin
      wr_ptr_d   = 4'd0;
      rd_ptr_d   = 4'd0;
      count_d    = 5'd0;
      overflow_d = 1'b0;
      pop_pend_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 4'd1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 4'd1;
      end
      count_d = count_q + {4'd0, push_ok} - {4'd0, do_pop};
      if (push_req && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (pop_pend_q && !read_qualified) begin
        pop_pend_d = 1'b0;
      end else if (rd_snap) begin
        pop_pend_d = 1'b1;
      end
    end
  end

  // All control state flops, asynchronously reset.
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      prescale_q  <= 16'd0;
      presc_cnt_q <= 16'd0;
      tstamp_q    <= 16'd0;
      sync1_q     <= 16'd0;
      sync2_q     <= 16'd0;
      prev_q      <= 16'd0;
      wr_ptr_q    <= 4'd0;
      rd_ptr_q    <= 4'd0;
      count_q     <= 5'd0;
      overflow_q  <= 1'b0;
      pop_pend_q  <= 1'b0;
      wq_prev_q   <= 1'b0;
      event_irq_q <= 1'b0;
    end else begin
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      tstamp_q    <= tstamp_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      pop_pend_q  <= pop_pend_d;
      wq_prev_q   <= wq_prev_d;
      event_irq_q <= event_irq_d;
    end
  end

  // Entry storage; contents are only observed through count-qualified reads.
  always_ff @(posedge xclk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Read mux; head-entry fields read 0 while the FIFO is empty.
  always_comb begin
    rd_data = 16'h0000;
    case (reg_sel)
      REG_CTRL:     rd_data = {13'd0, irq_en_q, 1'b0, enable_q};
      REG_STATUS:   rd_data = {5'd0, overflow_q, fifo_full, fifo_empty, 3'd0, count_q};
      REG_TSTAMP:   rd_data = fifo_empty ? 16'h0000 : head_entry[15:0];
      REG_SNAP:     rd_data = fifo_empty ? 16'h0000 : head_entry[31:16];
      REG_PRESCALE: rd_data = prescale_q;
      default:      rd_data = 16'h0000;
    endcase
  end

  assign data_avail = reset & read_qualified & addr_hit;
  assign db_out     = data_avail ? rd_data : 16'h0000;
  assign event_irq  = event_irq_q;

endmodule

// File: tb/tb_dig_in_event_fifo.sv
// Testbench for dig_in_event_fifo: directed bus reads/writes and input
// toggles, with a scoreboard queue checked by a separate read monitor.
module tb_dig_in_event_fifo;

  logic        xclk = 1'b0;
  logic        reset;
  logic        write_qualified;
  logic        read_qualified;
  logic [7:0]  ab;
  logic [15:0] db_in;
  logic [15:0] db_out;
  logic        data_avail;
  logic [15:0] dig_in;
  logic        event_irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  dig_in_event_fifo dut (
    .xclk            (xclk),
    .reset           (reset),
    .write_qualified (write_qualified),
    .read_qualified  (read_qualified),
    .ab              (ab),
    .db_in           (db_in),
    .db_out          (db_out),
    .data_avail      (data_avail),
    .dig_in          (dig_in),
    .event_irq       (event_irq)
  );

  // Clock and edge counter
  always #5 xclk = ~xclk;
  always @(posedge xclk) cyc++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {15'd0, act}, {15'd0, exp});
  endtask

  // Driver: multi-cycle write; second cycle carries junk data that must be ignored.
  task automatic wr(input logic [7:0] addr, input logic [15:0] data, output int eff_edge);
    @(negedge xclk);
    ab = addr;
    db_in = data;
    write_qualified = 1'b1;
    eff_edge = cyc + 1;
    @(negedge xclk);
    db_in = ~data;
    @(negedge xclk);
    write_qualified = 1'b0;
    db_in = 16'h0000;
  endtask

  // Driver: read held for 'hold' edges; expected value goes to the scoreboard.
  task automatic rd(input logic [7:0] addr, input logic [15:0] exp, input string name,
                    input int hold);
    @(negedge xclk);
    exp_q.push_back(exp);
    name_q.push_back(name);
    ab = addr;
    read_qualified = 1'b1;
    repeat (hold) @(negedge xclk);
    read_qualified = 1'b0;
  endtask

  // Driver: change inputs; the entry lands on the third following edge.
  task automatic ev(input logic [15:0] value, output int push_edge);
    @(negedge xclk);
    dig_in = value;
    push_edge = cyc + 3;
  endtask

  // Monitor: compare at the start of each claimed read, then check it holds.
  logic        prev_da = 1'b0;
  logic [15:0] cur_exp = 16'h0000;
  string       cur_name = "none";
  always @(negedge xclk) begin
    #1;
    if (data_avail && !prev_da) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_claim: got %h expected no read", db_out);
      end else begin
        cur_exp  = exp_q.pop_front();
        cur_name = name_q.pop_front();
        check(cur_name, db_out, cur_exp);
      end
    end else if (data_avail && prev_da) begin
      check({cur_name, "_hold"}, db_out, cur_exp);
    end
    prev_da = data_avail;
  end

  initial begin
    int c;
    int p;
    int e;
    int pe[17];

    reset = 1'b1;
    write_qualified = 1'b0;
    read_qualified = 1'b0;
    ab = 8'h00;
    db_in = 16'h0000;
    dig_in = 16'h0000;
    #2 reset = 1'b0;
    repeat (3) @(negedge xclk);
    reset = 1'b1;
    @(negedge xclk);
    #1;
    check_bit("rst_irq", event_irq, 1'b0);
    check_bit("rst_avail", data_avail, 1'b0);
    check("rst_dbout", db_out, 16'h0000);

    // Reset register values; SNAP on an empty FIFO must not pop.
    rd(8'h60, 16'h0000, "ctrl_rst", 1);
    rd(8'h61, 16'h0100, "status_rst", 1);
    rd(8'h62, 16'h0000, "tstamp_rst", 1);
    rd(8'h63, 16'h0000, "snap_empty", 3);
    rd(8'h61, 16'h0100, "status_after_empty_snap", 1);
    rd(8'h64, 16'h0000, "prescale_rst", 1);

    // Unclaimed address.
    @(negedge xclk);
    ab = 8'h65;
    read_qualified = 1'b1;
    #1;
    check_bit("unclaimed_avail", data_avail, 1'b0);
    check("unclaimed_dbout", db_out, 16'h0000);
    @(negedge xclk);
    read_qualified = 1'b0;

    // Configure: prescale 3, then enable+clear+irq_en to zero the timestamp.
    wr(8'h64, 16'h0003, e);
    rd(8'h64, 16'h0003, "prescale_wr", 1);
    wr(8'h60, 16'h0007, c);
    rd(8'h60, 16'h0005, "ctrl_wr", 1);

    // Single event: latency and irq timing.
    ev(16'h0001, p);
    repeat (3) @(negedge xclk);
    #1;
    check_bit("irq_before_reg", event_irq, 1'b0);
    @(negedge xclk);
    #1;
    check_bit("irq_after_push", event_irq, 1'b1);
    rd(8'h61, 16'h0001, "status_one", 1);
    rd(8'h62, 16'((p - 1 - c) >> 2), "tstamp_one", 1);
    rd(8'h63, 16'h0001, "snap_one", 4);
    rd(8'h61, 16'h0100, "status_popped", 1);
    @(negedge xclk);
    #1;
    check_bit("irq_after_pop", event_irq, 1'b0);

    // 17 events without reads: 16 stored, last dropped, overflow set.
    for (int i = 0; i < 17; i++) begin
      ev(16'h0100 + 16'(i), pe[i]);
      @(negedge xclk);
    end
    repeat (5) @(negedge xclk);
    rd(8'h61, 16'h0610, "status_overflow", 1);
    #1;
    check_bit("irq_full", event_irq, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd(8'h62, 16'((pe[i] - 1 - c) >> 2), "drain_ts", 1);
      rd(8'h63, 16'h0100 + 16'(i), "drain_snap", 2);
    end
    rd(8'h61, 16'h0500, "status_drained", 1);

    // Refill to full with overflow cleared, then push coincident with pop.
    wr(8'h60, 16'h0007, c);
    rd(8'h61, 16'h0100, "status_cleared", 1);
    for (int i = 0; i < 16; i++) begin
      ev(16'h0200 + 16'(i), p);
      @(negedge xclk);
    end
    repeat (5) @(negedge xclk);
    rd(8'h61, 16'h0210, "status_full", 1);
    @(negedge xclk);
    exp_q.push_back(16'h0200);
    name_q.push_back("coinc_snap");
    ab = 8'h63;
    read_qualified = 1'b1;
    dig_in = 16'h0A5A;
    @(negedge xclk);
    @(negedge xclk);
    read_qualified = 1'b0;
    repeat (4) @(negedge xclk);
    rd(8'h61, 16'h0210, "status_coinc", 1);
    for (int i = 1; i < 16; i++) begin
      rd(8'h63, 16'h0200 + 16'(i), "fill_snap", 1);
    end
    rd(8'h63, 16'h0A5A, "tail_snap", 1);
    rd(8'h61, 16'h0100, "status_fill_drained", 1);

    // Clear with events pending and irq_en dropped.
    ev(16'h0300, p);
    @(negedge xclk);
    ev(16'h0301, p);
    repeat (5) @(negedge xclk);
    rd(8'h61, 16'h0002, "status_pending", 1);
    @(negedge xclk);
    #1;
    check_bit("irq_pending", event_irq, 1'b1);
    wr(8'h60, 16'h0003, c);
    repeat (2) @(negedge xclk);
    #1;
    check_bit("irq_after_clear", event_irq, 1'b0);
    rd(8'h61, 16'h0100, "status_after_clear", 1);
    rd(8'h60, 16'h0001, "ctrl_no_irq", 1);
    ev(16'h0302, p);
    repeat (5) @(negedge xclk);
    rd(8'h61, 16'h0001, "status_post_clear", 1);
    rd(8'h62, 16'((p - 1 - c) >> 2), "tstamp_restart", 1);
    #1;
    check_bit("irq_masked", event_irq, 1'b0);
    rd(8'h63, 16'h0302, "snap_post_clear", 2);

    // Reset in the middle of a SNAP read with two entries queued.
    ev(16'h0400, p);
    @(negedge xclk);
    ev(16'h0401, p);
    repeat (5) @(negedge xclk);
    rd(8'h61, 16'h0002, "status_two", 1);
    @(negedge xclk);
    exp_q.push_back(16'h0400);
    name_q.push_back("rst_snap");
    ab = 8'h63;
    read_qualified = 1'b1;
    @(negedge xclk);
    @(negedge xclk);
    reset = 1'b0;
    @(negedge xclk);
    read_qualified = 1'b0;
    @(negedge xclk);
    reset = 1'b1;
    repeat (3) @(negedge xclk);
    rd(8'h61, 16'h0100, "status_after_reset", 1);
    rd(8'h60, 16'h0000, "ctrl_after_reset", 1);
    rd(8'h64, 16'h0000, "prescale_after_reset", 1);
    #1;
    check_bit("irq_after_reset", event_irq, 1'b0);
    repeat (10) @(negedge xclk);
    rd(8'h61, 16'h0100, "status_no_underflow", 1);

    repeat (3) @(negedge xclk);
    check("scoreboard_left", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
